// File: rtl/ram_pkg.sv
// Shared definitions for the banked data memory: controller states and
// size helpers derived from the address split.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int num_banks(input int bank_bits);
        return 1 << bank_bits;
    endfunction

    function automatic int bank_depth(input int addr_width, input int bank_bits);
        return 1 << (addr_width - bank_bits);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One true dual-port bank with registered, read-old-data outputs on both ports.
// Cross-port write conflicts are resolved by the caller before they reach here.
module ram_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int OFF_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  i_we_a,
    input  logic [OFF_WIDTH-1:0]  i_addr_a,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic                  i_we_b,
    input  logic [OFF_WIDTH-1:0]  i_addr_b,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    output logic [DATA_WIDTH-1:0] o_q_a,
    output logic [DATA_WIDTH-1:0] o_q_b
);

    localparam int DEPTH = 1 << OFF_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset branch; zeroing is a sequenced write driven from the top.
    always_ff @(posedge clk) begin
        if (i_we_b) r_mem[i_addr_b] <= i_data_b;
        if (i_we_a) r_mem[i_addr_a] <= i_data_a;
        // NOTE: non-blocking reads sample the array before this edge's writes land (read-old-data).
        o_q_a <= r_mem[i_addr_a];
        o_q_b <= r_mem[i_addr_b];
    end

endmodule

// File: rtl/banked_ram.sv
// Multi-bank true dual-port data memory: bank select from address MSBs,
// post-reset clearing, port-A-wins write arbitration and a collision pulse.
module banked_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int BANK_BITS      = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_a,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  busy,
    output logic                  collision
);

    localparam int NUM_BANKS  = num_banks(BANK_BITS);
    localparam int BANK_DEPTH = bank_depth(ADDR_WIDTH, BANK_BITS);
    localparam int OFF_WIDTH  = ADDR_WIDTH - BANK_BITS;
    localparam int SEL_WIDTH  = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam logic [OFF_WIDTH-1:0] LAST_OFF = OFF_WIDTH'(BANK_DEPTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [OFF_WIDTH-1:0]  r_clr_cnt;
    logic [SEL_WIDTH-1:0]  w_bank_a;
    logic [SEL_WIDTH-1:0]  w_bank_b;
    logic [SEL_WIDTH-1:0]  r_bank_a;
    logic [SEL_WIDTH-1:0]  r_bank_b;
    logic [OFF_WIDTH-1:0]  w_off_a;
    logic [OFF_WIDTH-1:0]  w_off_b;
    logic                  w_busy;
    logic                  w_same_addr;
    logic                  w_user_we_a;
    logic                  w_user_we_b;
    logic                  r_rd_en;
    logic                  r_collision;
    logic [NUM_BANKS-1:0]  w_we_a_bank;
    logic [NUM_BANKS-1:0]  w_we_b_bank;
    logic [OFF_WIDTH-1:0]  w_bank_addr_a;
    logic [DATA_WIDTH-1:0] w_bank_data_a;
    logic [DATA_WIDTH-1:0] w_bank_q_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_q_b [NUM_BANKS];

    generate
        if (BANK_BITS > 0) begin : g_sel
            assign w_bank_a = addr_a[ADDR_WIDTH-1 -: SEL_WIDTH];
            assign w_bank_b = addr_b[ADDR_WIDTH-1 -: SEL_WIDTH];
        end else begin : g_nosel
            assign w_bank_a = '0;
            assign w_bank_b = '0;
        end
    endgenerate

    assign w_off_a     = addr_a[OFF_WIDTH-1:0];
    assign w_off_b     = addr_b[OFF_WIDTH-1:0];
    assign w_busy      = (r_state == CLEAR);
    assign w_same_addr = (addr_a == addr_b);
    assign w_user_we_a = we_a && !w_busy && !reset;
    // Port A wins a same-address write; B's write is simply dropped.
    assign w_user_we_b = we_b && !w_busy && !reset && !(w_user_we_a && w_same_addr);

    always_ff @(posedge clk) begin
        if (reset) r_state <= CLEAR_ON_RESET ? CLEAR : READY;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (r_clr_cnt == LAST_OFF) w_next_state = READY;
            READY:   w_next_state = READY;
            default: w_next_state = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt   <= '0;
            r_rd_en     <= 1'b0;
            r_collision <= 1'b0;
            r_bank_a    <= '0;
            r_bank_b    <= '0;
        end else begin
            if (w_busy) r_clr_cnt <= r_clr_cnt + 1'b1;
            r_rd_en     <= !w_busy;
            r_collision <= w_user_we_a && we_b && w_same_addr;
            r_bank_a    <= w_bank_a;
            r_bank_b    <= w_bank_b;
        end
    end

    // While clearing, port A of every bank is borrowed to zero one offset per cycle.
    always_comb begin
        w_bank_addr_a = w_busy ? r_clr_cnt : w_off_a;
        w_bank_data_a = w_busy ? '0 : data_a;
        w_we_a_bank   = '0;
        w_we_b_bank   = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            w_we_a_bank[k] = w_busy || (w_user_we_a && (w_bank_a == SEL_WIDTH'(k)));
            w_we_b_bank[k] = w_user_we_b && (w_bank_b == SEL_WIDTH'(k));
        end
    end

    generate
        for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
            ram_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .OFF_WIDTH  (OFF_WIDTH)
            ) u_bank (
                .clk      (clk),
                .i_we_a   (w_we_a_bank[k]),
                .i_addr_a (w_bank_addr_a),
                .i_data_a (w_bank_data_a),
                .i_we_b   (w_we_b_bank[k]),
                .i_addr_b (w_off_b),
                .i_data_b (data_b),
                .o_q_a    (w_bank_q_a[k]),
                .o_q_b    (w_bank_q_b[k])
            );
        end
    endgenerate

    assign q_a       = r_rd_en ? w_bank_q_a[r_bank_a] : '0;
    assign q_b       = r_rd_en ? w_bank_q_b[r_bank_b] : '0;
    assign busy      = w_busy;
    assign collision = r_collision;

endmodule

// File: tb/tb_banked_ram.sv
// Bench for banked_ram: default configuration plus a four-bank, no-clear instance.
module tb_banked_ram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        reset;
    logic [15:0] data_a, data_b, q_a, q_b;
    logic [9:0]  addr_a, addr_b;
    logic        we_a, we_b, busy, collision;

    logic        reset2;
    logic [15:0] data_a2, data_b2, q_a2, q_b2;
    logic [9:0]  addr_a2, addr_b2;
    logic        we_a2, we_b2, busy2, collision2;

    banked_ram u_dut (
        .clk(clk), .reset(reset),
        .data_a(data_a), .data_b(data_b), .addr_a(addr_a), .addr_b(addr_b),
        .we_a(we_a), .we_b(we_b), .q_a(q_a), .q_b(q_b),
        .busy(busy), .collision(collision)
    );

    banked_ram #(.BANK_BITS(2), .CLEAR_ON_RESET(1'b0)) u_dut4 (
        .clk(clk), .reset(reset2),
        .data_a(data_a2), .data_b(data_b2), .addr_a(addr_a2), .addr_b(addr_b2),
        .we_a(we_a2), .we_b(we_b2), .q_a(q_a2), .q_b(q_b2),
        .busy(busy2), .collision(collision2)
    );

    typedef struct {
        logic        we_a;
        logic [9:0]  addr_a;
        logic [15:0] data_a;
        logic        we_b;
        logic [9:0]  addr_b;
        logic [15:0] data_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_col;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_col;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wa, input logic [9:0] aa, input logic [15:0] da,
                                input logic wb, input logic [9:0] ab, input logic [15:0] db,
                                input logic [15:0] ea, input logic [15:0] eb, input logic ec);
        vec_t v;
        v.we_a = wa; v.addr_a = aa; v.data_a = da;
        v.we_b = wb; v.addr_b = ab; v.data_b = db;
        v.exp_a = ea; v.exp_b = eb; v.exp_col = ec;
        return v;
    endfunction

    task automatic drive(input logic wa, input logic [9:0] aa, input logic [15:0] da,
                         input logic wb, input logic [9:0] ab, input logic [15:0] db);
        we_a = wa; addr_a = aa; data_a = da;
        we_b = wb; addr_b = ab; data_b = db;
    endtask

    // Drive one cycle of stimulus, queue what must appear after the edge, then compare.
    task automatic step(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        drive(v.we_a, v.addr_a, v.data_a, v.we_b, v.addr_b, v.data_b);
        e.name = name; e.exp_a = v.exp_a; e.exp_b = v.exp_b; e.exp_col = v.exp_col;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        check({got.name, ".q_a"}, {16'h0, q_a}, {16'h0, got.exp_a});
        check({got.name, ".q_b"}, {16'h0, q_b}, {16'h0, got.exp_b});
        check({got.name, ".collision"}, {31'h0, collision}, {31'h0, got.exp_col});
        check({got.name, ".busy"}, {31'h0, busy}, 32'h0);
    endtask

    // Count edges until busy drops; optionally attempt user writes while still clearing.
    task automatic run_clear(input int poke_at, output int n, output int leak);
        n = 0;
        leak = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (busy && (q_a !== 16'h0 || q_b !== 16'h0 || collision !== 1'b0)) leak++;
            if (n == poke_at)
                drive(1'b1, 10'h070, 16'hDEAD, 1'b1, 10'h070, 16'hBEEF);
            else if (n == poke_at + 1)
                drive(1'b1, 10'h270, 16'hCAFE, 1'b1, 10'h270, 16'hF00D);
            else if (n == poke_at + 2)
                drive(1'b0, 10'h0, 16'h0, 1'b0, 10'h0, 16'h0);
        end
        drive(1'b0, 10'h0, 16'h0, 1'b0, 10'h0, 16'h0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int leak;

        tbl[0]  = mk(1, 10'h005, 16'h1234, 0, 10'h005, 16'h0,    16'h0000, 16'h0000, 0);
        tbl[1]  = mk(1, 10'h205, 16'hABCD, 0, 10'h205, 16'h0,    16'h0000, 16'h0000, 0);
        tbl[2]  = mk(0, 10'h005, 16'h0,    0, 10'h205, 16'h0,    16'h1234, 16'hABCD, 0);
        tbl[3]  = mk(0, 10'h205, 16'h0,    0, 10'h005, 16'h0,    16'hABCD, 16'h1234, 0);
        tbl[4]  = mk(1, 10'h100, 16'h1111, 1, 10'h100, 16'h2222, 16'h0000, 16'h0000, 1);
        tbl[5]  = mk(0, 10'h100, 16'h0,    0, 10'h100, 16'h0,    16'h1111, 16'h1111, 0);
        tbl[6]  = mk(1, 10'h010, 16'h0001, 0, 10'h010, 16'h0,    16'h0000, 16'h0000, 0);
        tbl[7]  = mk(1, 10'h010, 16'h0002, 0, 10'h010, 16'h0,    16'h0001, 16'h0001, 0);
        tbl[8]  = mk(0, 10'h010, 16'h0,    0, 10'h010, 16'h0,    16'h0002, 16'h0002, 0);
        tbl[9]  = mk(1, 10'h020, 16'h5555, 1, 10'h030, 16'h6666, 16'h0000, 16'h0000, 0);
        tbl[10] = mk(0, 10'h030, 16'h0,    0, 10'h020, 16'h0,    16'h6666, 16'h5555, 0);
        tbl[11] = mk(1, 10'h3FF, 16'h7777, 1, 10'h000, 16'h8888, 16'h0000, 16'h0000, 0);
        tbl[12] = mk(0, 10'h000, 16'h0,    0, 10'h3FF, 16'h0,    16'h8888, 16'h7777, 0);
        tbl[13] = mk(1, 10'h060, 16'h0101, 1, 10'h260, 16'h0202, 16'h0000, 16'h0000, 0);
        tbl[14] = mk(0, 10'h260, 16'h0,    0, 10'h060, 16'h0,    16'h0202, 16'h0101, 0);
        tbl[15] = mk(0, 10'h040, 16'h0,    1, 10'h040, 16'h9999, 16'h0000, 16'h0000, 0);
        tbl[16] = mk(0, 10'h040, 16'h0,    0, 10'h100, 16'h0,    16'h9999, 16'h1111, 0);

        reset  = 1'b1;
        reset2 = 1'b1;
        drive(1'b0, 10'h0, 16'h0, 1'b0, 10'h0, 16'h0);
        we_a2 = 1'b0; we_b2 = 1'b0; addr_a2 = '0; addr_b2 = '0; data_a2 = '0; data_b2 = '0;

        // Reset values, then the initial clear.
        @(negedge clk);
        check("rst.q_a", {16'h0, q_a}, 32'h0);
        check("rst.q_b", {16'h0, q_b}, 32'h0);
        check("rst.collision", {31'h0, collision}, 32'h0);
        check("rst.busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        run_clear(-10, n, leak);
        check("clear0.busy_cycles", n, 512);
        check("clear0.outputs_quiet", leak, 0);

        // Preload all-ones, pulse reset, then confirm the words are zero again.
        step(mk(1, 10'h000, 16'hFFFF, 1, 10'h3FF, 16'hFFFF, 16'h0, 16'h0, 0), "pre.w0");
        step(mk(1, 10'h1FF, 16'hFFFF, 1, 10'h200, 16'hFFFF, 16'h0, 16'h0, 0), "pre.w1");
        step(mk(0, 10'h000, 16'h0, 0, 10'h3FF, 16'h0, 16'hFFFF, 16'hFFFF, 0), "pre.r0");
        step(mk(0, 10'h1FF, 16'h0, 0, 10'h200, 16'h0, 16'hFFFF, 16'hFFFF, 0), "pre.r1");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pulse.busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        run_clear(-10, n, leak);
        check("clear1.busy_cycles", n, 512);
        step(mk(0, 10'h000, 16'h0, 0, 10'h3FF, 16'h0, 16'h0000, 16'h0000, 0), "clr.r0");
        step(mk(0, 10'h1FF, 16'h0, 0, 10'h200, 16'h0, 16'h0000, 16'h0000, 0), "clr.r1");

        for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Reset 200 cycles into a clear; writes attempted late in the restarted clear must not stick.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) @(posedge clk);
        @(negedge clk);
        check("mid.busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_clear(300, n, leak);
        check("mid.busy_cycles", n, 512);
        check("mid.outputs_quiet", leak, 0);
        step(mk(0, 10'h070, 16'h0, 0, 10'h270, 16'h0, 16'h0000, 16'h0000, 0), "mid.ignored");

        // Four banks, no clear: ready straight out of reset.
        @(negedge clk);
        check("b4.rst.busy", {31'h0, busy2}, 32'h0);
        check("b4.rst.q_a", {16'h0, q_a2}, 32'h0);
        check("b4.rst.q_b", {16'h0, q_b2}, 32'h0);
        reset2 = 1'b0;
        we_a2 = 1'b1; addr_a2 = 10'h000; data_a2 = 16'hA000;
        we_b2 = 1'b1; addr_b2 = 10'h100; data_b2 = 16'hB100;
        @(posedge clk); @(negedge clk);
        check("b4.busy", {31'h0, busy2}, 32'h0);
        addr_a2 = 10'h200; data_a2 = 16'hC200;
        addr_b2 = 10'h300; data_b2 = 16'hD300;
        @(posedge clk); @(negedge clk);
        we_a2 = 1'b0; we_b2 = 1'b0;
        addr_a2 = 10'h000; addr_b2 = 10'h100;
        @(posedge clk); @(negedge clk);
        check("b4.r000", {16'h0, q_a2}, 32'hA000);
        check("b4.r100", {16'h0, q_b2}, 32'hB100);
        addr_a2 = 10'h200; addr_b2 = 10'h300;
        @(posedge clk); @(negedge clk);
        check("b4.r200", {16'h0, q_a2}, 32'hC200);
        check("b4.r300", {16'h0, q_b2}, 32'hD300);
        addr_a2 = 10'h300; addr_b2 = 10'h000;
        @(posedge clk); @(negedge clk);
        check("b4.r300a", {16'h0, q_a2}, 32'hD300);
        check("b4.r000b", {16'h0, q_b2}, 32'hA000);
        check("b4.collision", {31'h0, collision2}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
